// File: rtl/mem_island_check_pkg.sv
// Shared types and helpers for the memory-island check controller.
package mem_island_check_pkg;

   // Run sequencing states; encoding is visible on state_o.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Saturating add for counters up to 32 bits wide. Bit 32 of the result
   // flags that the true sum did not fit in w bits; bits [31:0] hold the
   // clamped value (all ones in the low w bits when saturated).
   function automatic logic [32:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned w);
      logic [32:0] sum;
      logic [32:0] max_val;
      sum     = {1'b0, a} + {1'b0, b};
      max_val = (33'd1 << w) - 33'd1;
      if ((sum >> w) != 33'd0) begin
         return {1'b1, max_val[31:0]};
      end
      return {1'b0, sum[31:0]};
   endfunction

endpackage

// File: rtl/mem_island_check_ctrl_popcount.sv
// Counts the set bits of a requester vector.
module mem_island_check_ctrl_popcount #(
   parameter int Width  = 6,
   parameter int CountW = $clog2(Width + 1)
) (
   input  logic [Width-1:0]  bits,
   output logic [CountW-1:0] count
);

   logic [CountW-1:0] bit_ext [Width];

   // Zero-extend each bit so the sum below runs at full count width.
   for (genvar gi = 0; gi < Width; gi++) begin : g_ext
      assign bit_ext[gi] = CountW'(bits[gi]);
   end

   // Plain adder chain; the tool balances it.
   always_comb begin
      count = '0;
      for (int i = 0; i < Width; i++) begin
         count = count + bit_ext[i];
      end
   end

endmodule

// File: rtl/mem_island_check_ctrl.sv
// Hardware pass/fail controller for the memory-island compare bench:
// sequences IDLE/RUN/DRAIN/DONE, counts mismatches and runs a watchdog.
module mem_island_check_ctrl
   import mem_island_check_pkg::*;
#(
   parameter int NumReq        = 6,
   parameter int CntWidth      = 16,
   parameter int TimeoutCycles = 100000,
   parameter int DrainCycles   = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [NumReq-1:0]   mismatch_i,
   input  logic [NumReq-1:0]   end_of_sim_i,
   input  logic [NumReq-1:0]   busy_i,
   output logic [CntWidth-1:0] err_cnt_o,
   output logic                err_sat_o,
   output logic [NumReq-1:0]   err_mask_o,
   output logic [1:0]          state_o,
   output logic                done_o,
   output logic                pass_o,
   output logic                timeout_o
);

   localparam int PopW  = $clog2(NumReq + 1);
   localparam int WdW   = $clog2(TimeoutCycles + 1);
   localparam int IdleW = $clog2(DrainCycles + 1);

   localparam logic [WdW-1:0]   WdLast   = WdW'(TimeoutCycles - 1);
   localparam logic [IdleW-1:0] IdleLast = IdleW'(DrainCycles - 1);

   state_e              state_reg,    state_next;
   logic [CntWidth-1:0] err_cnt_reg,  err_cnt_next;
   logic                err_sat_reg,  err_sat_next;
   logic [NumReq-1:0]   err_mask_reg, err_mask_next;
   logic [NumReq-1:0]   seen_reg,     seen_next;
   logic [WdW-1:0]      wd_cnt_reg,   wd_cnt_next;
   logic [IdleW-1:0]    idle_cnt_reg, idle_cnt_next;
   logic                done_reg,     done_next;
   logic                pass_reg,     pass_next;
   logic                timeout_reg,  timeout_next;

   logic [PopW-1:0]     pop;
   logic [CntWidth:0]   sum_wide;

   mem_island_check_ctrl_popcount #(
      .Width  (NumReq),
      .CountW (PopW)
   ) u_popcount (
      .bits  (mismatch_i),
      .count (pop)
   );

   // One extra bit on the adder; its carry means the count overflowed.
   assign sum_wide = {1'b0, err_cnt_reg} + (CntWidth + 1)'(pop);

   // Next-state, counter and status computation.
   always_comb begin
      state_next    = state_reg;
      err_cnt_next  = err_cnt_reg;
      err_sat_next  = err_sat_reg;
      err_mask_next = err_mask_reg;
      seen_next     = seen_reg;
      wd_cnt_next   = wd_cnt_reg;
      idle_cnt_next = idle_cnt_reg;
      timeout_next  = timeout_reg;

      case (state_reg)
         IDLE, DONE: begin
            if (start_i) begin
               state_next    = RUN;
               err_cnt_next  = '0;
               err_sat_next  = 1'b0;
               err_mask_next = '0;
               seen_next     = '0;
               wd_cnt_next   = '0;
               idle_cnt_next = '0;
               timeout_next  = 1'b0;
            end
         end
         RUN: begin
            seen_next = seen_reg | end_of_sim_i;
            if ((seen_reg | end_of_sim_i) == '1) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (busy_i != '0) begin
               idle_cnt_next = '0;
            end else begin
               idle_cnt_next = idle_cnt_reg + 1'b1;
               if (idle_cnt_reg == IdleLast) begin
                  state_next = DONE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // Error accounting and watchdog only while a run is live.
      if (state_reg == RUN || state_reg == DRAIN) begin
         err_mask_next = err_mask_reg | mismatch_i;
         if (sum_wide[CntWidth]) begin
            err_cnt_next = '1;
            err_sat_next = 1'b1;
         end else begin
            err_cnt_next = sum_wide[CntWidth-1:0];
         end
         wd_cnt_next = wd_cnt_reg + 1'b1;
         if (wd_cnt_reg == WdLast) begin
            state_next   = DONE;
            timeout_next = 1'b1;
         end
      end

      // Verdict uses the post-edge count so a last-cycle mismatch fails the run.
      done_next = (state_next == DONE);
      pass_next = (state_next == DONE) && (err_cnt_next == '0) && !timeout_next;
   end

   // State and all outputs registered; asynchronous clear aborts any run.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg    <= IDLE;
         err_cnt_reg  <= '0;
         err_sat_reg  <= 1'b0;
         err_mask_reg <= '0;
         seen_reg     <= '0;
         wd_cnt_reg   <= '0;
         idle_cnt_reg <= '0;
         done_reg     <= 1'b0;
         pass_reg     <= 1'b0;
         timeout_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         err_cnt_reg  <= err_cnt_next;
         err_sat_reg  <= err_sat_next;
         err_mask_reg <= err_mask_next;
         seen_reg     <= seen_next;
         wd_cnt_reg   <= wd_cnt_next;
         idle_cnt_reg <= idle_cnt_next;
         done_reg     <= done_next;
         pass_reg     <= pass_next;
         timeout_reg  <= timeout_next;
      end
   end

   assign err_cnt_o  = err_cnt_reg;
   assign err_sat_o  = err_sat_reg;
   assign err_mask_o = err_mask_reg;
   assign state_o    = state_reg;
   assign done_o     = done_reg;
   assign pass_o     = pass_reg;
   assign timeout_o  = timeout_reg;

endmodule

// File: tb/tb_mem_island_check_ctrl.sv
// Directed bench for mem_island_check_ctrl (4-bit counter, 100-cycle watchdog).
module tb_mem_island_check_ctrl;

   localparam int NumReq        = 6;
   localparam int CntWidth      = 4;
   localparam int TimeoutCycles = 100;
   localparam int DrainCycles   = 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic [NumReq-1:0]   mismatch = '0;
   logic [NumReq-1:0]   eos = '0;
   logic [NumReq-1:0]   busy = '0;
   logic [CntWidth-1:0] err_cnt;
   logic                err_sat;
   logic [NumReq-1:0]   err_mask;
   logic [1:0]          state;
   logic                done;
   logic                pass;
   logic                timeout;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_island_check_ctrl #(
      .NumReq        (NumReq),
      .CntWidth      (CntWidth),
      .TimeoutCycles (TimeoutCycles),
      .DrainCycles   (DrainCycles)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .mismatch_i   (mismatch),
      .end_of_sim_i (eos),
      .busy_i       (busy),
      .err_cnt_o    (err_cnt),
      .err_sat_o    (err_sat),
      .err_mask_o   (err_mask),
      .state_o      (state),
      .done_o       (done),
      .pass_o       (pass),
      .timeout_o    (timeout)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(2);
      n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", state, S_IDLE); end
      n_checks++; if ({err_cnt, err_sat, err_mask, done, pass, timeout} !== '0) begin n_fail++; $display("FAIL reset_outputs got cnt=%0d sat=%0b mask=%b done=%0b pass=%0b to=%0b exp all 0", err_cnt, err_sat, err_mask, done, pass, timeout); end
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         mismatch = (i % 2 == 0) ? 6'h3F : 6'h00;
         tick(1);
      end
      mismatch = '0;
      n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL idle_nostart_state got %0d exp %0d", state, S_IDLE); end
      n_checks++; if (err_cnt !== 4'd0 || err_mask !== 6'h00) begin n_fail++; $display("FAIL idle_mismatch_ignored got cnt=%0d mask=%b exp 0/000000", err_cnt, err_mask); end
      $display("test_reset: state=%0d err_cnt=%0d", state, err_cnt);
   endtask

   task automatic test_clean_run();
      start = 1'b1; tick(1); start = 1'b0;
      n_checks++; if (state !== S_RUN) begin n_fail++; $display("FAIL clean_enter_run got %0d exp %0d", state, S_RUN); end
      for (int i = 0; i < 5; i++) begin
         eos[i] = 1'b1;
         tick(4);
      end
      n_checks++; if (state !== S_RUN) begin n_fail++; $display("FAIL clean_partial_eos got %0d exp %0d", state, S_RUN); end
      eos[5] = 1'b1; tick(1);
      n_checks++; if (state !== S_DRAIN) begin n_fail++; $display("FAIL clean_enter_drain got %0d exp %0d", state, S_DRAIN); end
      tick(7);
      n_checks++; if (state !== S_DRAIN) begin n_fail++; $display("FAIL clean_drain7 got %0d exp %0d", state, S_DRAIN); end
      tick(1);
      n_checks++; if (state !== S_DONE || done !== 1'b1) begin n_fail++; $display("FAIL clean_done got state=%0d done=%0b exp 3/1", state, done); end
      n_checks++; if (pass !== 1'b1 || err_cnt !== 4'd0 || timeout !== 1'b0) begin n_fail++; $display("FAIL clean_pass got pass=%0b cnt=%0d to=%0b exp 1/0/0", pass, err_cnt, timeout); end
      $display("test_clean_run: state=%0d pass=%0b err_cnt=%0d", state, pass, err_cnt);
   endtask

   task automatic test_errors();
      eos = '0; start = 1'b1; tick(1); start = 1'b0;
      mismatch = 6'b000101; tick(1);
      n_checks++; if (err_cnt !== 4'd2) begin n_fail++; $display("FAIL err_latency got %0d exp 2", err_cnt); end
      tick(2); mismatch = '0;
      n_checks++; if (err_cnt !== 4'd6) begin n_fail++; $display("FAIL err_cnt3 got %0d exp 6", err_cnt); end
      n_checks++; if (err_mask !== 6'b000101) begin n_fail++; $display("FAIL err_mask got %b exp 000101", err_mask); end
      eos = 6'h3F; tick(1); tick(8);
      n_checks++; if (state !== S_DONE || pass !== 1'b0 || err_cnt !== 4'd6) begin n_fail++; $display("FAIL err_done got state=%0d pass=%0b cnt=%0d exp 3/0/6", state, pass, err_cnt); end
      $display("test_errors: err_cnt=%0d mask=%b pass=%0b", err_cnt, err_mask, pass);
   endtask

   task automatic test_drain_restart();
      eos = 6'h3F; start = 1'b1; tick(1); start = 1'b0;
      n_checks++; if (state !== S_RUN || err_cnt !== 4'd0 || err_mask !== 6'h00) begin n_fail++; $display("FAIL restart_clear got state=%0d cnt=%0d mask=%b exp 1/0/000000", state, err_cnt, err_mask); end
      tick(1);
      n_checks++; if (state !== S_DRAIN) begin n_fail++; $display("FAIL dr_enter got %0d exp %0d", state, S_DRAIN); end
      tick(5);
      busy[2] = 1'b1; tick(1); busy = '0;
      n_checks++; if (state !== S_DRAIN) begin n_fail++; $display("FAIL dr_busy got %0d exp %0d", state, S_DRAIN); end
      tick(7);
      n_checks++; if (state !== S_DRAIN) begin n_fail++; $display("FAIL dr_not_early got %0d exp %0d", state, S_DRAIN); end
      mismatch = 6'b000010; tick(1); mismatch = '0;
      n_checks++; if (state !== S_DONE || err_cnt !== 4'd1 || err_mask !== 6'b000010) begin n_fail++; $display("FAIL dr_last_mismatch got state=%0d cnt=%0d mask=%b exp 3/1/000010", state, err_cnt, err_mask); end
      n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL dr_pass got %0b exp 0", pass); end
      mismatch = 6'h3F; tick(1); mismatch = '0;
      n_checks++; if (err_cnt !== 4'd1) begin n_fail++; $display("FAIL done_ignores_mismatch got %0d exp 1", err_cnt); end
      $display("test_drain_restart: state=%0d err_cnt=%0d", state, err_cnt);
   endtask

   task automatic test_timeout();
      eos = 6'b101111; start = 1'b1; tick(1); start = 1'b0;
      tick(98);
      n_checks++; if (state !== S_RUN || timeout !== 1'b0) begin n_fail++; $display("FAIL to_before got state=%0d to=%0b exp 1/0", state, timeout); end
      tick(1);
      n_checks++; if (state !== S_RUN) begin n_fail++; $display("FAIL to_cycle99 got %0d exp %0d", state, S_RUN); end
      tick(1);
      n_checks++; if (state !== S_DONE || timeout !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL to_done got state=%0d to=%0b done=%0b exp 3/1/1", state, timeout, done); end
      n_checks++; if (pass !== 1'b0 || err_cnt !== 4'd0) begin n_fail++; $display("FAIL to_pass got pass=%0b cnt=%0d exp 0/0", pass, err_cnt); end
      $display("test_timeout: state=%0d timeout=%0b pass=%0b", state, timeout, pass);
   endtask

   task automatic test_saturation();
      eos = '0; mismatch = 6'h3F; start = 1'b1; tick(1); start = 1'b0;
      n_checks++; if (err_cnt !== 4'd0 || timeout !== 1'b0) begin n_fail++; $display("FAIL sat_entry got cnt=%0d to=%0b exp 0/0", err_cnt, timeout); end
      tick(2);
      n_checks++; if (err_cnt !== 4'd12 || err_sat !== 1'b0) begin n_fail++; $display("FAIL sat_pre got cnt=%0d sat=%0b exp 12/0", err_cnt, err_sat); end
      tick(1); mismatch = '0;
      n_checks++; if (err_cnt !== 4'd15 || err_sat !== 1'b1) begin n_fail++; $display("FAIL sat_clamp got cnt=%0d sat=%0b exp 15/1", err_cnt, err_sat); end
      eos = 6'h3F; tick(1); tick(8);
      n_checks++; if (state !== S_DONE || err_cnt !== 4'd15 || err_sat !== 1'b1 || pass !== 1'b0) begin n_fail++; $display("FAIL sat_done got state=%0d cnt=%0d sat=%0b pass=%0b exp 3/15/1/0", state, err_cnt, err_sat, pass); end
      start = 1'b1; eos = '0; tick(1); start = 1'b0;
      n_checks++; if (err_cnt !== 4'd0 || err_sat !== 1'b0 || err_mask !== 6'h00 || done !== 1'b0) begin n_fail++; $display("FAIL sat_restart got cnt=%0d sat=%0b mask=%b done=%0b exp 0/0/0/0", err_cnt, err_sat, err_mask, done); end
      tick(3);
      rst = 1'b1; #1;
      n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL async_rst got %0d exp %0d", state, S_IDLE); end
      rst = 1'b0; tick(2);
      n_checks++; if (state !== S_IDLE || done !== 1'b0) begin n_fail++; $display("FAIL rst_stays_idle got state=%0d done=%0b exp 0/0", state, done); end
      $display("test_saturation: err_cnt=%0d sat=%0b state=%0d", err_cnt, err_sat, state);
   endtask

   initial begin
      test_reset();
      test_clean_run();
      test_errors();
      test_drain_restart();
      test_timeout();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
